// File: rtl/kronos_hpm_bank.sv
// ---------------------------------------------------------------------------
// kronos_hpm_bank
//
// Hardware performance-monitor counter bank for the Kronos CSR unit.
// Holds NUM_COUNTERS counters of COUNTER_W bits:
//   index 0 -> mcycle   (CSR n = 0), increments every cycle
//   index 1 -> minstret (CSR n = 2), increments on instret
//   index i -> mhpmcounterN (CSR n = i+1), increments on hpm_event[sel-1]
//              where sel is the counter's mhpmevent register (1..EVENT_W)
// Counters use a staggered 32-bit carry: a low-half wrap is latched in
// carry_q and added to the high half one cycle later. High-half reads add
// the pending carry so software always sees a coherent value.
//
// Address map:
//   0xB00+n  low half of counter n      0xB80+n  high half (zero-extended)
//   0x320    mcountinhibit              0x320+n  mhpmevent (n >= 3)
//   0x7C0    sticky overflow, W1C       (only with KRONOS_HPM_OVERFLOW_EN)
//
// Optional feature macro: KRONOS_HPM_OVERFLOW_EN
//   defined   -> overflow register at 0x7C0 and registered hpm_irq
//   undefined -> 0x7C0 unmapped, hpm_irq tied to 0
//
// Ports:
//   clk          clock
//   rstz         synchronous reset, active-high
//   instret      one instruction retired this cycle
//   hpm_event    one-cycle event pulses [EVENT_W]
//   csr_addr     CSR address [12]
//   csr_rd_en    read strobe
//   csr_wr_en    write strobe
//   csr_wr_data  write data [32]
//   csr_rd_data  read data [32], combinational, 0 when csr_rd_en=0
//   csr_hit      csr_addr decodes to a bank register
//   hpm_irq      overflow interrupt
// ---------------------------------------------------------------------------
module kronos_hpm_bank #(
   parameter int NUM_COUNTERS = 4,
   parameter int COUNTER_W    = 64,
   parameter int EVENT_W      = 8
) (
   input  logic               clk,
   input  logic               rstz,
   input  logic               instret,
   input  logic [EVENT_W-1:0] hpm_event,
   input  logic [11:0]        csr_addr,
   input  logic               csr_rd_en,
   input  logic               csr_wr_en,
   input  logic [31:0]        csr_wr_data,
   output logic [31:0]        csr_rd_data,
   output logic               csr_hit,
   output logic               hpm_irq
);

   localparam int HI_W  = COUNTER_W - 32;
   localparam int SEL_W = EVENT_W + 1;

   // Counter index to CSR number: index 0 is mcycle (n=0); n=1 is the
   // time CSR, which lives elsewhere, so every later index shifts by one.
   function automatic logic [4:0] idx2n(input int i);
      return (i == 0) ? 5'd0 : 5'(i + 1);
   endfunction

   function automatic logic [31:0] impl_mask();
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < NUM_COUNTERS; i++) m[idx2n(i)] = 1'b1;
      return m;
   endfunction

   localparam logic [31:0] IMPL_MASK = impl_mask();

   logic [31:0]        r_lo      [NUM_COUNTERS];
   logic [HI_W-1:0]    r_hi      [NUM_COUNTERS];
   logic [SEL_W-1:0]   r_evt     [NUM_COUNTERS];
   logic [NUM_COUNTERS-1:0] r_carry;
   logic [31:0]        r_inhibit;

   logic [NUM_COUNTERS-1:0] w_src;
   logic [NUM_COUNTERS-1:0] w_inc;
   logic [NUM_COUNTERS-1:0] w_wr_lo;
   logic [NUM_COUNTERS-1:0] w_wr_hi;
   logic [NUM_COUNTERS-1:0] w_wr_evt;
   logic [NUM_COUNTERS-1:0] w_wrap;
   logic [HI_W-1:0]    w_hi_rd   [NUM_COUNTERS];
   logic               w_wr_inh;
   logic               w_hit;
   logic [31:0]        w_rd;

   assign w_wr_inh = csr_wr_en && (csr_addr == 12'h320);

   // Per-counter increment source, write decode and low-half wrap detect
   always_comb begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         w_wr_lo[i]  = csr_wr_en && (csr_addr == 12'hB00 + {7'd0, idx2n(i)});
         w_wr_hi[i]  = csr_wr_en && (csr_addr == 12'hB80 + {7'd0, idx2n(i)});
         w_wr_evt[i] = 1'b0;
         w_src[i]    = 1'b0;
         if (i == 0) begin
            w_src[i] = 1'b1;
         end else if (i == 1) begin
            w_src[i] = instret;
         end else begin
            w_wr_evt[i] = csr_wr_en && (csr_addr == 12'h320 + {7'd0, idx2n(i)});
            // Selector values outside 1..EVENT_W leave the counter idle
            for (int e = 0; e < EVENT_W; e++) begin
               if (r_evt[i] == SEL_W'(e + 1)) w_src[i] = hpm_event[e];
            end
         end
         w_inc[i]  = w_src[i] & ~r_inhibit[idx2n(i)];
         // A low write overrides the increment, so it can never wrap
         w_wrap[i] = w_inc[i] & ~w_wr_lo[i] & (r_lo[i] == 32'hFFFF_FFFF);
         // Coherent high view: physical high plus the carry still in flight
         w_hi_rd[i] = r_hi[i] + HI_W'(r_carry[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rstz) begin
         for (int i = 0; i < NUM_COUNTERS; i++) begin
            r_lo[i]  <= '0;
            r_hi[i]  <= '0;
            r_evt[i] <= '0;
         end
         r_carry   <= '0;
         r_inhibit <= '0;
      end else begin
         for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (w_wr_lo[i])
               r_lo[i] <= csr_wr_data;
            else if (w_inc[i])
               r_lo[i] <= r_lo[i] + 32'd1;

            // High write discards any pending carry; otherwise apply it
            if (w_wr_hi[i])
               r_hi[i] <= csr_wr_data[HI_W-1:0];
            else if (r_carry[i])
               r_hi[i] <= r_hi[i] + HI_W'(1);

            r_carry[i] <= w_wrap[i];

            if (w_wr_evt[i])
               r_evt[i] <= csr_wr_data[SEL_W-1:0];
         end
         if (w_wr_inh)
            r_inhibit <= csr_wr_data & IMPL_MASK;
      end
   end

`ifdef KRONOS_HPM_OVERFLOW_EN
   logic [31:0] r_ovf;
   logic        r_irq;
   logic [31:0] w_ovf_set;
   logic [31:0] w_ovf_clr;

   // High half wraps when a carry lands on an all-ones high half that is
   // not being overwritten in the same cycle
   always_comb begin
      w_ovf_set = '0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         if (r_carry[i] && !w_wr_hi[i] && (&r_hi[i]))
            w_ovf_set[idx2n(i)] = 1'b1;
      end
      w_ovf_clr = (csr_wr_en && (csr_addr == 12'h7C0)) ? csr_wr_data : 32'd0;
   end

   always_ff @(posedge clk) begin
      if (rstz) begin
         r_ovf <= '0;
         r_irq <= 1'b0;
      end else begin
         // Set wins over a simultaneous write-1-to-clear
         r_ovf <= ((r_ovf & ~w_ovf_clr) | w_ovf_set) & IMPL_MASK;
         r_irq <= |r_ovf;
      end
   end

   assign hpm_irq = r_irq;
`else
   assign hpm_irq = 1'b0;
`endif

   // Read mux: purely combinational from registers
   always_comb begin
      w_hit = 1'b0;
      w_rd  = 32'd0;
      if (csr_addr == 12'h320) begin
         w_hit = 1'b1;
         w_rd  = r_inhibit;
      end
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         if (csr_addr == 12'hB00 + {7'd0, idx2n(i)}) begin
            w_hit = 1'b1;
            w_rd  = r_lo[i];
         end
         if (csr_addr == 12'hB80 + {7'd0, idx2n(i)}) begin
            w_hit = 1'b1;
            w_rd  = 32'(w_hi_rd[i]);
         end
         if ((i >= 2) && (csr_addr == 12'h320 + {7'd0, idx2n(i)})) begin
            w_hit = 1'b1;
            w_rd  = 32'(r_evt[i]);
         end
      end
`ifdef KRONOS_HPM_OVERFLOW_EN
      if (csr_addr == 12'h7C0) begin
         w_hit = 1'b1;
         w_rd  = r_ovf;
      end
`endif
   end

   assign csr_hit     = w_hit;
   assign csr_rd_data = csr_rd_en ? w_rd : 32'd0;

endmodule
